priv_1_13_clint: RTL and testbench
==================================

# priv_1_13_clint

Core-local interruptor for the priv 1.13 privilege unit. It holds the memory-mapped `msip`, `mtime` and `mtimecmp` registers behind a single-cycle word bus. It converts their state into the set/clear pulse pairs (`soft_int_m`/`clear_soft_int_m`, `timer_int_m`/`clear_timer_int_m`) that the interrupt/exception handler consumes to update `mip`. It sits directly upstream of that handler, between the system bus and the privilege unit.

## Interface
Parameters:
- `PRESCALE`, default 1: core clocks per `mtime` tick; legal range 1..65535.
- `BASE_ADDR`, default 32'h0200_0000: region base; only `addr[15:0]` is decoded.

Ports:
- `CLK` in 1: sole clock, rising edge.
- `nRST` in 1: reset, asynchronous and active-high (asserted when 1).
- `req` in 1: bus request, one word access per cycle.
- `wen` in 1: 1 = write, 0 = read; sampled with `req`.
- `addr` in 32: byte address; must be word-aligned.
- `wdata` in 32: write data.
- `rdata` out 32: read data, valid while `ack` is high.
- `ack` out 1: one-cycle completion pulse.
- `bus_err` out 1: pulses with `ack` on an unmapped or misaligned access.
- `soft_int_m`, `clear_soft_int_m` out 1: set/clear pulses for `mip.msip`.
- `timer_int_m`, `clear_timer_int_m` out 1: set/clear pulses for `mip.mtip`.
- `timer_int_s`, `clear_timer_int_s` out 1: present only under the macro; see Configuration.

## Operation
Register map (offsets from `BASE_ADDR`):
- 0x0000 `msip`: bit 0 only; other bits read 0.
- 0x4000 / 0x4004: `mtimecmp` lo/hi.
- 0xBFF8 / 0xBFFC: `mtime` lo/hi.

Reset values:
- `mtime` = 0.
- `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
- `msip` = 0.
- Prescaler count = 0.
- Every output = 0.

`mtime`:
- 64-bit unsigned register; increments by 1 when the prescaler reaches `PRESCALE-1`, then the prescaler returns to 0.
- Wraps from all-ones to 0 with no side effect.
- A bus write to either half replaces that half, and the write wins over a same-cycle increment. The other half keeps its current value and is not incremented that cycle.
- The prescaler is not reset by `mtime` writes.

Timer level:
- `mt_lvl = (mtime >= mtimecmp)`, a 64-bit unsigned compare on registered values.
- A registered copy `mt_lvl_q` is kept.
- `timer_int_m` pulses for one cycle when `mt_lvl & ~mt_lvl_q`.
- `clear_timer_int_m` pulses for one cycle when `~mt_lvl & mt_lvl_q`.

Software interrupt:
- Writing `msip` 0→1 pulses `soft_int_m`; writing 1→0 pulses `clear_soft_int_m`.
- Rewriting the same value produces no pulse.

Pulse rules:
- A set pulse and a clear pulse for the same bit are never asserted together.
- Pulses come from edges of the level, so software sees no lost or duplicated edges.

Bus:
- Each accepted `req` produces exactly one `ack` on the next cycle; back-to-back requests are allowed.
- Reads return the value that was registered at the request edge.
- A misaligned or unmapped access still acks, returns `rdata` 0, ignores the write, and pulses `bus_err`.

Reset mid-operation:
- All state returns to reset values immediately.
- A pending `ack` is dropped.
- No pulses are emitted in the first cycle after reset deassertion.

## Timing
- Bus write at edge N: register updated at N; level and edge detect settle so the pulse appears in cycle N+1 (one-cycle latency from write to pulse).
- Counter-driven crossing: the `mtime` increment at edge N gives a pulse in cycle N+1.
- Read: `req` in cycle N → `ack` and `rdata` in cycle N+1.
- 64-bit reads are not atomic. Software reads hi, lo, hi and retries on mismatch; the block adds no latching.

## Configuration
Macro `PRIV_1_13_CLINT_STIMECMP_EN`.

Defined:
- Adds the 64-bit `stimecmp` register at 0x5000 (lo) / 0x5004 (hi), reset value all-ones.
- Adds the ports `timer_int_s` / `clear_timer_int_s`, driven by the same edge rule applied to `mtime >= stimecmp`.

Undefined:
- Offsets 0x5000/0x5004 are unmapped (they raise `bus_err`).
- The two ports do not exist.
- The handler ties its `timer_int_s` / `clear_timer_int_s` inputs to 0.

## Structure
- Package `machine_mode_types_1_13_pkg` gains:
  - `CLINT_MSIP_OFF`, `CLINT_MTIMECMP_OFF`, `CLINT_MTIME_OFF` and `CLINT_STIMECMP_OFF` localparams.
  - A `clint_sel_t` enum for the address decode.
- One sub-module, `priv_1_13_clint_edge`, instantiated once per interrupt source (two, or three with the macro). It registers a level and emits the set/clear pulses.

## Test plan
- Reset: check all outputs are 0. Read 0xBFF8 → 0. Read 0x4004 → 32'hFFFF_FFFF.
- `PRESCALE`=4, `mtimecmp`=10, `mtime`=0 → `timer_int_m` pulses once when `mtime` reaches 10 (about 40 cycles after the write), and never again while `mtime` ≥ 10.
- With that interrupt already pulsed, write `mtimecmp` lo = 0xFFFF_FFFF → `clear_timer_int_m` pulses on the next cycle.
- `msip` writes 1, 1, 0 → `soft_int_m` pulses once, then `clear_soft_int_m` pulses once; the second write of 1 produces nothing.
- `mtime` = 64'h0000_0000_FFFF_FFFF with a tick → `mtime` = 64'h1_0000_0000. Then `mtime` = all-ones → wraps to 0, and `clear_timer_int_m` pulses if `mtimecmp` is nonzero.
- Read 0x0008 → `ack`, `bus_err`, `rdata` = 0. Assert `nRST` between a `req` and its `ack` → no `ack`, and all registers are at reset values.

Source files
------------

// File: rtl/machine_mode_types_1_13_pkg.sv
// ----------------------------------------------------------------------------
// machine_mode_types_1_13_pkg
//
// Shared definitions for the priv 1.13 machine-mode blocks.
// This file holds the pieces used by the core-local interruptor (CLINT):
//   - CLINT_*_OFF  : register offsets within the CLINT region.
//   - clint_sel_t  : result of decoding a bus offset into a register select.
//   - clint_decode : maps a 16-bit region offset to a clint_sel_t.
//     SEL_NONE means the access is unmapped or misaligned.
// ----------------------------------------------------------------------------
package machine_mode_types_1_13_pkg;

  // Register offsets relative to the CLINT base address.
  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_STIMECMP_OFF = 16'h5000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  // Width of the mtime prescaler counter.
  // It covers the whole legal PRESCALE range, 1..65535.
  localparam int CLINT_PRESCALE_W = 16;

  // Register selected by a bus access.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIMECMP_LO,
    SEL_MTIMECMP_HI,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_STIMECMP_LO,
    SEL_STIMECMP_HI
  } clint_sel_t;

  // Decode a region offset into a register select.
  // A misaligned offset never matches a register, so it decodes to SEL_NONE.
  // The stimecmp pair only decodes when that register is built in.
  function automatic clint_sel_t clint_decode(input logic [15:0] off,
                                              input logic       stimecmp_en);
    clint_sel_t sel;
    sel = SEL_NONE;
    if (off[1:0] == 2'b00) begin
      if (off == CLINT_MSIP_OFF) begin
        sel = SEL_MSIP;
      end else if (off == CLINT_MTIMECMP_OFF) begin
        sel = SEL_MTIMECMP_LO;
      end else if (off == CLINT_MTIMECMP_OFF + 16'd4) begin
        sel = SEL_MTIMECMP_HI;
      end else if (off == CLINT_MTIME_OFF) begin
        sel = SEL_MTIME_LO;
      end else if (off == CLINT_MTIME_OFF + 16'd4) begin
        sel = SEL_MTIME_HI;
      end else if (stimecmp_en && (off == CLINT_STIMECMP_OFF)) begin
        sel = SEL_STIMECMP_LO;
      end else if (stimecmp_en && (off == CLINT_STIMECMP_OFF + 16'd4)) begin
        sel = SEL_STIMECMP_HI;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/priv_1_13_clint_edge.sv
// ----------------------------------------------------------------------------
// priv_1_13_clint_edge
//
// Turns one interrupt level into set/clear pulse pairs for a mip bit.
// The block keeps a registered copy of the level:
//   - set_pulse is high for the cycle in which the level has risen
//     relative to that registered copy.
//   - clr_pulse is high for the cycle in which the level has fallen.
// The two pulses are therefore never high together.
//
// Ports:
//   clk       in  1 : clock, rising edge
//   rst       in  1 : asynchronous active-high reset
//   lvl       in  1 : interrupt level, derived from registered state upstream
//   set_pulse out 1 : one-cycle pulse on a rising level
//   clr_pulse out 1 : one-cycle pulse on a falling level
// ----------------------------------------------------------------------------
module priv_1_13_clint_edge (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic set_pulse,
  output logic clr_pulse
);

  logic lvl_q;

  // Level history.
  // Reset clears it; every source level is also 0 at reset, so no edge
  // can be seen in the first cycle after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl;
    end
  end

  // The level is itself a function of registers only.
  // So these pulses change only just after a clock edge.
  assign set_pulse = lvl & ~lvl_q;
  assign clr_pulse = ~lvl & lvl_q;

endmodule

// File: rtl/priv_1_13_clint.sv
// ----------------------------------------------------------------------------
// priv_1_13_clint
//
// Core-local interruptor for the priv 1.13 privilege unit.
// It holds msip, mtime and mtimecmp behind a single-cycle word bus.
// It turns their state into the set/clear pulse pairs that the
// interrupt/exception handler uses to update mip.
//
// Register map (offsets from BASE_ADDR; only addr[15:0] is decoded):
//   0x0000        msip (bit 0)
//   0x4000/0x4004 mtimecmp lo/hi
//   0x5000/0x5004 stimecmp lo/hi   (only with PRIV_1_13_CLINT_STIMECMP_EN)
//   0xBFF8/0xBFFC mtime lo/hi
//
// Configuration macro: PRIV_1_13_CLINT_STIMECMP_EN
//   Adds the stimecmp register and the timer_int_s/clear_timer_int_s ports.
//   When the macro is undefined, 0x5000/0x5004 are unmapped.
//
// Parameters:
//   PRESCALE  : core clocks per mtime tick, 1..65535
//   BASE_ADDR : region base address
//
// Ports:
//   CLK               in  1  : clock, rising edge
//   nRST              in  1  : asynchronous reset, active high
//   req               in  1  : bus request, one word access per cycle
//   wen               in  1  : 1 = write, 0 = read
//   addr              in  32 : byte address
//   wdata             in  32 : write data
//   rdata             out 32 : read data, valid with ack
//   ack               out 1  : completion pulse, the cycle after req
//   bus_err           out 1  : with ack, for an unmapped or misaligned access
//   soft_int_m        out 1  : set pulse for mip.msip
//   clear_soft_int_m  out 1  : clear pulse for mip.msip
//   timer_int_m       out 1  : set pulse for mip.mtip
//   clear_timer_int_m out 1  : clear pulse for mip.mtip
//   timer_int_s       out 1  : set pulse for mip.stip (macro only)
//   clear_timer_int_s out 1  : clear pulse for mip.stip (macro only)
// ----------------------------------------------------------------------------
module priv_1_13_clint
  import machine_mode_types_1_13_pkg::*;
#(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        bus_err,
  output logic        soft_int_m,
  output logic        clear_soft_int_m,
  output logic        timer_int_m,
  output logic        clear_timer_int_m
`ifdef PRIV_1_13_CLINT_STIMECMP_EN
  ,
  output logic        timer_int_s,
  output logic        clear_timer_int_s
`endif
);

`ifdef PRIV_1_13_CLINT_STIMECMP_EN
  localparam logic STIMECMP_EN = 1'b1;
`else
  localparam logic STIMECMP_EN = 1'b0;
`endif

  localparam logic [CLINT_PRESCALE_W-1:0] PRESC_MAX =
    CLINT_PRESCALE_W'(PRESCALE - 1);

  logic [15:0]                 offset;
  logic                        misaligned;
  clint_sel_t                  sel;
  logic                        bad_access;
  logic                        wr_en;
  logic [CLINT_PRESCALE_W-1:0] presc_cnt;
  logic                        tick;
  logic [63:0]                 mtime;
  logic [63:0]                 mtimecmp;
  logic                        msip;
  logic [31:0]                 rd_next;
  logic                        mt_lvl;
  logic                        unused_addr_hi;

  // The upper address bits are decoded by the system bus, not here.
  assign unused_addr_hi = ^addr[31:16];

  // Address decode.
  // A misaligned address and an unmapped offset are handled the same way:
  // the access is acked with bus_err, and any write is dropped.
  assign offset     = addr[15:0] - BASE_ADDR[15:0];
  assign misaligned = |addr[1:0];
  assign sel        = clint_decode(offset, STIMECMP_EN);
  assign bad_access = misaligned | (sel == SEL_NONE);
  assign wr_en      = req & wen & ~bad_access;

  // Prescaler.
  // It free-runs from reset, and mtime writes do not disturb it.
  // Software therefore cannot change the tick phase.
  assign tick = (presc_cnt == PRESC_MAX);

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      presc_cnt <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // mtime.
  // A write to one half beats a same-cycle tick. The other half is
  // deliberately left alone, so a carry cannot ripple into freshly
  // written data. All-ones simply wraps to zero.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      mtime <= '0;
    end else if (wr_en && (sel == SEL_MTIME_LO)) begin
      mtime[31:0] <= wdata;
    end else if (wr_en && (sel == SEL_MTIME_HI)) begin
      mtime[63:32] <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp.
  // Its all-ones reset value keeps the machine timer quiet until
  // software programs a deadline.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      mtimecmp <= '1;
    end else if (wr_en && (sel == SEL_MTIMECMP_LO)) begin
      mtimecmp[31:0] <= wdata;
    end else if (wr_en && (sel == SEL_MTIMECMP_HI)) begin
      mtimecmp[63:32] <= wdata;
    end
  end

  // msip.
  // Only bit 0 is stored. The soft-interrupt pulses come from its edges,
  // so rewriting the same value produces no pulse.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      msip <= 1'b0;
    end else if (wr_en && (sel == SEL_MSIP)) begin
      msip <= wdata[0];
    end
  end

`ifdef PRIV_1_13_CLINT_STIMECMP_EN
  logic [63:0] stimecmp;
  logic        st_lvl;

  // stimecmp: the supervisor timer deadline, reset to all-ones like mtimecmp.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      stimecmp <= '1;
    end else if (wr_en && (sel == SEL_STIMECMP_LO)) begin
      stimecmp[31:0] <= wdata;
    end else if (wr_en && (sel == SEL_STIMECMP_HI)) begin
      stimecmp[63:32] <= wdata;
    end
  end
`endif

  // Read mux.
  // It samples the registers as they stand at the request edge, so a read
  // never sees a write or tick that lands on that same edge.
  // Writes and errored accesses return 0.
  always_comb begin
    rd_next = '0;
    if (req && !wen && !bad_access) begin
      case (sel)
        SEL_MSIP:        rd_next = {31'd0, msip};
        SEL_MTIMECMP_LO: rd_next = mtimecmp[31:0];
        SEL_MTIMECMP_HI: rd_next = mtimecmp[63:32];
        SEL_MTIME_LO:    rd_next = mtime[31:0];
        SEL_MTIME_HI:    rd_next = mtime[63:32];
`ifdef PRIV_1_13_CLINT_STIMECMP_EN
        SEL_STIMECMP_LO: rd_next = stimecmp[31:0];
        SEL_STIMECMP_HI: rd_next = stimecmp[63:32];
`endif
        default:         rd_next = '0;
      endcase
    end
  end

  // Bus response.
  // Every request is answered exactly once, in the following cycle.
  // Reset clears a pending ack at once.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      ack     <= 1'b0;
      bus_err <= 1'b0;
      rdata   <= '0;
    end else begin
      ack     <= req;
      bus_err <= req & bad_access;
      rdata   <= rd_next;
    end
  end

  // The timer levels compare registered values only.
  // A write or tick at one edge therefore produces its pulse in the very
  // next cycle.
  assign mt_lvl = (mtime >= mtimecmp);

  priv_1_13_clint_edge u_soft_m (
    .clk       (CLK),
    .rst       (nRST),
    .lvl       (msip),
    .set_pulse (soft_int_m),
    .clr_pulse (clear_soft_int_m)
  );

  priv_1_13_clint_edge u_timer_m (
    .clk       (CLK),
    .rst       (nRST),
    .lvl       (mt_lvl),
    .set_pulse (timer_int_m),
    .clr_pulse (clear_timer_int_m)
  );

`ifdef PRIV_1_13_CLINT_STIMECMP_EN
  assign st_lvl = (mtime >= stimecmp);

  priv_1_13_clint_edge u_timer_s (
    .clk       (CLK),
    .rst       (nRST),
    .lvl       (st_lvl),
    .set_pulse (timer_int_s),
    .clr_pulse (clear_timer_int_s)
  );
`endif

endmodule

// File: tb/tb_priv_1_13_clint.sv
// ----------------------------------------------------------------------------
// tb_priv_1_13_clint
//
// Self-checking bench for priv_1_13_clint, built with PRESCALE = 4.
// A behavioural model holds mtime, mtimecmp, msip and a cycle phase as
// plain numbers. It predicts ack/rdata/bus_err and the interrupt pulses
// from the before/after comparison levels of every clock edge.
// Directed scenarios are followed by randomized bus traffic.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_priv_1_13_clint;

  localparam int unsigned PRESC = 4;
  localparam logic [31:0] BASE  = 32'h0200_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        bus_err;
  logic        soft_int_m;
  logic        clear_soft_int_m;
  logic        timer_int_m;
  logic        clear_timer_int_m;
`ifdef PRIV_1_13_CLINT_STIMECMP_EN
  logic        timer_int_s;
  logic        clear_timer_int_s;
`endif

  int vec_count = 0;
  int err_count = 0;

  // Reference model state.
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic [63:0] m_scmp;
  logic        m_msip;
  int          m_pcnt;

  // Expectations for the current cycle.
  logic        exp_ack;
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic        exp_si;
  logic        exp_sc;
  logic        exp_ti;
  logic        exp_tc;
  logic        exp_ssi;
  logic        exp_ssc;

  int timer_set_seen;
  int timer_clr_seen;

  always #5 CLK = ~CLK;

  priv_1_13_clint #(
    .PRESCALE  (PRESC),
    .BASE_ADDR (BASE)
  ) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .req               (req),
    .wen               (wen),
    .addr              (addr),
    .wdata             (wdata),
    .rdata             (rdata),
    .ack               (ack),
    .bus_err           (bus_err),
    .soft_int_m        (soft_int_m),
    .clear_soft_int_m  (clear_soft_int_m),
    .timer_int_m       (timer_int_m),
    .clear_timer_int_m (clear_timer_int_m)
`ifdef PRIV_1_13_CLINT_STIMECMP_EN
    ,
    .timer_int_s       (timer_int_s),
    .clear_timer_int_s (clear_timer_int_s)
`endif
  );

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Return the model to its power-on state.
  task automatic model_reset();
    m_time = 64'd0;
    m_cmp  = '1;
    m_scmp = '1;
    m_msip = 1'b0;
    m_pcnt = 0;
  endtask

  // Register addressed by a byte address: 0 = unmapped or misaligned.
  function automatic int model_sel(input logic [31:0] a);
    case (a[15:0])
      16'h0000: return 1;
      16'h4000: return 2;
      16'h4004: return 3;
      16'hBFF8: return 4;
      16'hBFFC: return 5;
`ifdef PRIV_1_13_CLINT_STIMECMP_EN
      16'h5000: return 6;
      16'h5004: return 7;
`endif
      default:  return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int s);
    case (s)
      1:       return {31'd0, m_msip};
      2:       return m_cmp[31:0];
      3:       return m_cmp[63:32];
      4:       return m_time[31:0];
      5:       return m_time[63:32];
      6:       return m_scmp[31:0];
      7:       return m_scmp[63:32];
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one clock edge with the given bus inputs.
  task automatic model_step(input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
    int s;
    bit tk;
    bit t_prev;
    bit ss_prev;
    bit sw_prev;
    s       = r ? model_sel(a) : 0;
    t_prev  = (m_time >= m_cmp);
    ss_prev = (m_time >= m_scmp);
    sw_prev = m_msip;
    exp_ack   = r;
    exp_err   = r && (s == 0);
    exp_rdata = (r && !w && s != 0) ? model_read(s) : 32'd0;
    tk     = (m_pcnt == int'(PRESC) - 1);
    m_pcnt = tk ? 0 : m_pcnt + 1;
    if (r && w && s == 4) begin
      m_time[31:0] = d;
    end else if (r && w && s == 5) begin
      m_time[63:32] = d;
    end else if (tk) begin
      m_time = m_time + 64'd1;
    end
    if (r && w) begin
      case (s)
        1: m_msip = d[0];
        2: m_cmp[31:0] = d;
        3: m_cmp[63:32] = d;
        6: m_scmp[31:0] = d;
        7: m_scmp[63:32] = d;
        default: ;
      endcase
    end
    exp_ti  = (m_time >= m_cmp) && !t_prev;
    exp_tc  = !(m_time >= m_cmp) && t_prev;
    exp_ssi = (m_time >= m_scmp) && !ss_prev;
    exp_ssc = !(m_time >= m_scmp) && ss_prev;
    exp_si  = m_msip && !sw_prev;
    exp_sc  = !m_msip && sw_prev;
  endtask

  // Drive one bus cycle, then check every output against the model
  // shortly after the edge.
  task automatic applyStimulus(input logic r, input logic w,
                               input logic [15:0] off, input logic [31:0] d);
    req   = r;
    wen   = w;
    addr  = BASE + {16'd0, off};
    wdata = d;
    @(posedge CLK);
    model_step(r, w, BASE + {16'd0, off}, d);
    #1;
    checkOutput("ack", ack, exp_ack);
    checkOutput("bus_err", bus_err, exp_err);
    checkOutput("rdata", rdata, exp_rdata);
    checkOutput("soft_int_m", soft_int_m, exp_si);
    checkOutput("clear_soft_int_m", clear_soft_int_m, exp_sc);
    checkOutput("timer_int_m", timer_int_m, exp_ti);
    checkOutput("clear_timer_int_m", clear_timer_int_m, exp_tc);
`ifdef PRIV_1_13_CLINT_STIMECMP_EN
    checkOutput("timer_int_s", timer_int_s, exp_ssi);
    checkOutput("clear_timer_int_s", clear_timer_int_s, exp_ssc);
`endif
    if (timer_int_m) timer_set_seen++;
    if (clear_timer_int_m) timer_clr_seen++;
    req = 1'b0;
    wen = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 32'd0);
  endtask

  // All outputs must be 0 while in reset and just after it.
  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_ack"}, ack, 1'b0);
    checkOutput({tag, "_bus_err"}, bus_err, 1'b0);
    checkOutput({tag, "_rdata"}, rdata, 32'd0);
    checkOutput({tag, "_pulses"},
                {soft_int_m, clear_soft_int_m, timer_int_m, clear_timer_int_m},
                4'b0000);
  endtask

  logic [15:0] offs [10];

  initial begin
    offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
             16'h5000, 16'h5004, 16'h0008, 16'h4002, 16'h0004};
    timer_set_seen = 0;
    timer_clr_seen = 0;
    nRST  = 1'b1;
    req   = 1'b0;
    wen   = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    checkQuiet("in_reset");
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    checkQuiet("post_reset");

    // Reset values as seen over the bus.
    applyStimulus(1'b1, 1'b0, 16'hBFF8, 32'd0);
    checkOutput("rd_mtime_lo_reset", rdata, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h4004, 32'd0);
    checkOutput("rd_mtimecmp_hi_reset", rdata, 32'hFFFF_FFFF);

    // Timer crossing: mtimecmp = 10 and mtime = 0, prescaler of 4.
    applyStimulus(1'b1, 1'b1, 16'h4004, 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h4000, 32'd10);
    applyStimulus(1'b1, 1'b1, 16'hBFFC, 32'd0);
    applyStimulus(1'b1, 1'b1, 16'hBFF8, 32'd0);
    timer_set_seen = 0;
    idle(60);
    checkOutput("timer_set_once", timer_set_seen, 1);

    // Moving the deadline away drops the level at once.
    applyStimulus(1'b1, 1'b1, 16'h4000, 32'hFFFF_FFFF);
    checkOutput("timer_clear_on_cmp_write", clear_timer_int_m, 1'b1);

    // msip writes 1, 1, 0.
    applyStimulus(1'b1, 1'b1, 16'h0000, 32'd1);
    checkOutput("soft_set", soft_int_m, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'h0000, 32'd1);
    checkOutput("soft_rewrite_quiet", {soft_int_m, clear_soft_int_m}, 2'b00);
    applyStimulus(1'b1, 1'b1, 16'h0000, 32'd0);
    checkOutput("soft_clear", clear_soft_int_m, 1'b1);

    // Carry from the low into the high half of mtime.
    applyStimulus(1'b1, 1'b1, 16'hBFFC, 32'd0);
    applyStimulus(1'b1, 1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    idle(4);
    applyStimulus(1'b1, 1'b0, 16'hBFFC, 32'd0);
    checkOutput("carry_hi", rdata, 32'd1);
    applyStimulus(1'b1, 1'b0, 16'hBFF8, 32'd0);

    // Wrap from all-ones to zero drops the timer level.
    applyStimulus(1'b1, 1'b1, 16'hBFF8, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b1, 16'hBFFC, 32'hFFFF_FFFF);
    timer_clr_seen = 0;
    idle(5);
    checkOutput("wrap_clear", timer_clr_seen, 1);

    // Unmapped and misaligned accesses.
    applyStimulus(1'b1, 1'b0, 16'h0008, 32'd0);
    checkOutput("unmapped_flags", {ack, bus_err}, 2'b11);
    checkOutput("unmapped_rdata", rdata, 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h4002, 32'd5);
    checkOutput("misaligned_err", bus_err, 1'b1);

    // Reset between a request and its ack.
    applyStimulus(1'b1, 1'b1, 16'h0000, 32'd1);
    applyStimulus(1'b1, 1'b0, 16'hBFF8, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checkOutput("reset_drops_ack", ack, 1'b0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    checkQuiet("mid_reset");
    applyStimulus(1'b1, 1'b0, 16'hBFF8, 32'd0);
    checkOutput("mid_reset_mtime", rdata, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h4004, 32'd0);
    checkOutput("mid_reset_cmp_hi", rdata, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 16'h0000, 32'd0);
    checkOutput("mid_reset_msip", rdata, 32'd0);

    // Randomized traffic with mostly small values, to provoke crossings.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        w;
      logic [31:0] d;
      r = ($urandom_range(0, 3) != 0);
      w = $urandom_range(0, 1) == 1;
      d = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
      applyStimulus(r, w, offs[$urandom_range(0, 9)], d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
